// File: rtl/weight_slice_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_slice_loader
// Description : Packs ks*ks streamed weight values into one kernel slice and
//               issues one slice-wide weight RAM write per completed slice.
//               Optional macro WEIGHT_LOADER_BASE_ADDR_EN adds a base_addr input.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_slice_loader #(
    parameter int DATA_WIDTH       = 16,
    parameter int KERNEL_SIZE_MAX  = 3,
    parameter int WRITE_ADDR_WIDTH = 10,
    parameter int KS_WIDTH         = 2
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start,
    input  logic [KS_WIDTH-1:0]                               kernel_size,
    input  logic [WRITE_ADDR_WIDTH-1:0]                       slice_count,
`ifdef WEIGHT_LOADER_BASE_ADDR_EN
    input  logic [WRITE_ADDR_WIDTH-1:0]                       base_addr,
`endif
    input  logic                                              s_valid,
    input  logic [DATA_WIDTH-1:0]                             s_data,
    output logic                                              s_ready,
    output logic                                              ena_w,
    output logic [WRITE_ADDR_WIDTH-1:0]                       addr_write,
    output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0] din,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              cfg_err
);

    localparam int c_ELEMS   = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
    localparam int c_SLICE_W = c_ELEMS * DATA_WIDTH;
    localparam int c_CNT_W   = $clog2(c_ELEMS + 1);
    localparam logic [KS_WIDTH-1:0] c_KS_MAX = KS_WIDTH'(KERNEL_SIZE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_SLICE_W-1:0]          r_buf;
    logic [c_SLICE_W-1:0]          w_slice;
    logic [c_CNT_W-1:0]            r_elem_cnt;
    logic [c_CNT_W-1:0]            r_ks_sq;
    logic [WRITE_ADDR_WIDTH-1:0]   r_slice_cnt;
    logic [WRITE_ADDR_WIDTH-1:0]   r_slice_total;
    logic [WRITE_ADDR_WIDTH-1:0]   w_addr;
    logic [c_CNT_W-1:0]            w_ks_ext;
    logic [c_CNT_W-1:0]            w_ks_sq;
    logic                          w_ks_ok;
    logic                          w_start_go;
    logic                          w_start_bad;
    logic                          w_start_empty;
    logic                          w_hs;
    logic                          w_slice_end;
    logic                          w_load_end;

    assign w_ks_ext = c_CNT_W'(kernel_size);
    assign w_ks_sq  = w_ks_ext * w_ks_ext;
    assign w_ks_ok  = (kernel_size != '0) && (kernel_size <= c_KS_MAX);
    assign s_ready  = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);

`ifdef WEIGHT_LOADER_BASE_ADDR_EN
    logic [WRITE_ADDR_WIDTH-1:0]   r_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
        end else if (w_start_go) begin
            r_base <= base_addr;
        end
    end

    // Address wraps modulo 2^WRITE_ADDR_WIDTH by natural truncation.
    assign w_addr = r_base + r_slice_cnt;
`else
    assign w_addr = r_slice_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_go    = 1'b0;
        w_start_bad   = 1'b0;
        w_start_empty = 1'b0;
        w_hs          = 1'b0;
        w_slice_end   = 1'b0;
        w_load_end    = 1'b0;
        w_slice       = r_buf;
        w_slice[r_elem_cnt*DATA_WIDTH +: DATA_WIDTH] = s_data;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!w_ks_ok) begin
                        w_start_bad = 1'b1;
                    end else if (slice_count == '0) begin
                        w_start_empty = 1'b1;
                    end else begin
                        w_start_go  = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_hs        = s_valid;
                w_slice_end = s_valid && (r_elem_cnt == r_ks_sq - 1'b1);
                w_load_end  = w_slice_end && (r_slice_cnt == r_slice_total - 1'b1);
                if (w_load_end) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf         <= '0;
            r_elem_cnt    <= '0;
            r_ks_sq       <= '0;
            r_slice_cnt   <= '0;
            r_slice_total <= '0;
            ena_w         <= 1'b0;
            addr_write    <= '0;
            din           <= '0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            ena_w   <= 1'b0;
            done    <= w_start_empty || (r_state == S_FIN);
            cfg_err <= w_start_bad;
            if (w_start_go) begin
                r_ks_sq       <= w_ks_sq;
                r_slice_total <= slice_count;
                r_slice_cnt   <= '0;
                r_elem_cnt    <= '0;
                r_buf         <= '0;
            end
            if (w_hs) begin
                if (w_slice_end) begin
                    // Buffer clears on the write edge so the next slice can start without a bubble.
                    ena_w       <= 1'b1;
                    din         <= w_slice;
                    addr_write  <= w_addr;
                    r_buf       <= '0;
                    r_elem_cnt  <= '0;
                    r_slice_cnt <= r_slice_cnt + 1'b1;
                end else begin
                    r_buf      <= w_slice;
                    r_elem_cnt <= r_elem_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_slice_loader.sv
`default_nettype none
// Scoreboard bench for weight_slice_loader: directed loads push expected
// writes/pulses into a queue that a negedge monitor drains and compares.
module tb_weight_slice_loader;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int KW = 2;
    localparam int SW = 144;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] kernel_size = '0;
    logic [AW-1:0] slice_count = '0;
    logic [AW-1:0] base_addr = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          ena_w;
    logic [AW-1:0] addr_write;
    logic [SW-1:0] din;
    logic          busy;
    logic          done;
    logic          cfg_err;

    weight_slice_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .kernel_size (kernel_size),
        .slice_count (slice_count),
`ifdef WEIGHT_LOADER_BASE_ADDR_EN
        .base_addr   (base_addr),
`endif
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .ena_w       (ena_w),
        .addr_write  (addr_write),
        .din         (din),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    // kind: 0 = slice write, 1 = done pulse, 2 = cfg_err pulse
    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [SW-1:0] din;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [SW-1:0] d);
        ev_t e;
        e.kind = 0; e.addr = a; e.din = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_pulse(input int kind);
        ev_t e;
        e.kind = kind; e.addr = '0; e.din = '0;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_event_kind%0d", kind), SW'(1), SW'(0));
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", SW'(kind), SW'(e.kind));
        if (kind == 0) begin
            chk("addr_write", SW'(addr_write), SW'(e.addr));
            chk("din", din, e.din);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ena_w)   observe(0);
            if (done)    observe(1);
            if (cfg_err) observe(2);
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [DW-1:0] v);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = v;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            chk("s_ready_wait", SW'(s_ready), SW'(1));
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_start(input logic [KW-1:0] ks, input logic [AW-1:0] cnt, input logic [AW-1:0] base);
        start       = 1'b1;
        kernel_size = ks;
        slice_count = cnt;
        base_addr   = base;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] v1 [18];
        v1 = '{16'h3c00, 16'h4000, 16'h3c00, 16'h4200, 16'h3c00, 16'h4000, 16'h3c00, 16'h0000, 16'h4000,
               16'h3c00, 16'h4000, 16'h4200, 16'h3c00, 16'h4000, 16'h3c00, 16'h0000, 16'h4200, 16'h0000};

        idle(2);
        chk("reset_ena_w",   SW'(ena_w), SW'(0));
        chk("reset_done",    SW'(done), SW'(0));
        chk("reset_cfg_err", SW'(cfg_err), SW'(0));
        chk("reset_busy",    SW'(busy), SW'(0));
        chk("reset_s_ready", SW'(s_ready), SW'(0));
        chk("reset_addr",    SW'(addr_write), SW'(0));
        chk("reset_din",     din, SW'(0));
        rst_n = 1'b1;
        idle(2);

        // Two back-to-back 3x3 slices.
        expect_write(10'd0, 144'h4000_0000_3c00_4000_3c00_4200_3c00_4000_3c00);
        expect_write(10'd1, 144'h0000_4200_0000_3c00_4000_3c00_4200_4000_3c00);
        expect_pulse(1);
        do_start(2'd3, 10'd2, 10'd0);
        chk("busy_after_start", SW'(busy), SW'(1));
        for (int i = 0; i < 18; i++) send(v1[i]);
        chk("s_ready_fin", SW'(s_ready), SW'(0));
        chk("busy_fin", SW'(busy), SW'(1));
        idle(1);
        chk("busy_after_done", SW'(busy), SW'(0));
        idle(3);

        // 2x2 slice, upper positions zero.
        expect_write(10'd0, 144'h0004_0003_0002_0001);
        expect_pulse(1);
        do_start(2'd2, 10'd1, 10'd0);
        for (int i = 1; i <= 4; i++) send(DW'(i));
        idle(4);

        // s_valid gapped every other cycle.
        expect_write(10'd0, 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001);
        expect_pulse(1);
        do_start(2'd3, 10'd1, 10'd0);
        for (int i = 1; i <= 9; i++) begin
            send(DW'(i));
            if (i == 8) chk("no_early_write", SW'(ena_w), SW'(0));
            if (i == 9) chk("write_after_9th", SW'(ena_w), SW'(1));
            else idle(1);
        end
        idle(4);

        // Bad kernel size, then zero slice count.
        expect_pulse(2);
        do_start(2'd0, 10'd1, 10'd0);
        chk("cfg_err_busy", SW'(busy), SW'(0));
        chk("cfg_err_pulse", SW'(cfg_err), SW'(1));
        idle(3);
        expect_pulse(1);
        do_start(2'd3, 10'd0, 10'd0);
        chk("empty_busy", SW'(busy), SW'(0));
        chk("empty_done", SW'(done), SW'(1));
        idle(3);

        // Abort mid-slice via reset, then a clean reload.
        do_start(2'd3, 10'd1, 10'd0);
        for (int i = 0; i < 5; i++) send(16'hdead);
        rst_n = 1'b0;
        idle(2);
        chk("abort_busy", SW'(busy), SW'(0));
        chk("abort_ena_w", SW'(ena_w), SW'(0));
        rst_n = 1'b1;
        idle(2);
        expect_write(10'd0, 144'h1009_1008_1007_1006_1005_1004_1003_1002_1001);
        expect_pulse(1);
        do_start(2'd3, 10'd1, 10'd0);
        for (int i = 1; i <= 9; i++) send(16'h1000 + DW'(i));
        idle(4);

`ifdef WEIGHT_LOADER_BASE_ADDR_EN
        expect_write(10'd1022, 144'h0011);
        expect_write(10'd1023, 144'h0022);
        expect_write(10'd0,    144'h0033);
        expect_pulse(1);
        do_start(2'd1, 10'd3, 10'd1022);
        send(16'h0011);
        send(16'h0022);
        send(16'h0033);
        idle(4);
`endif

        chk("scoreboard_drained", SW'(exp_q.size()), SW'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
